mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS-subset control FSM. Sequences fetch/decode/execute/memory/writeback for the datapath.
//  Directly upstream of the 32-bit 4:1 muxes: drives their 2-bit selects (ALUSRCB, PCSRC) every cycle.
//  Also drives the register/memory write enables and the memory request handshake.
// PARAMETERS
//  WAIT_MAX      default 0   max wait cycles per memory access; 0 = unbounded; else overrun -> EXCEPT
//  ILLEGAL_TRAP  default 1   1 = unknown opcode -> EXCEPT; 0 = unknown opcode treated as NOP (-> FETCH)
// PORTS
//  CLK        in   1  rising-edge clock
//  RST_N      in   1  asynchronous, active-low reset
//  OP         in   6  instruction opcode from IR[31:26]
//  ZERO       in   1  ALU zero flag
//  MEM_READY  in   1  memory done this cycle (read data valid / write accepted)
//  MEM_REQ    out  1  memory access request
//  IORD       out  1  address mux: 0 = PC, 1 = ALUOut
//  MEMWRITE   out  1  memory write strobe
//  IRWRITE    out  1  IR load enable
//  REGDST     out  1  write-register select: 0 = rt, 1 = rd
//  MEMTOREG   out  1  writeback data select: 0 = ALUOut, 1 = MDR
//  REGWRITE   out  1  register file write enable
//  ALUSRCA    out  1  ALU A select: 0 = PC, 1 = regA
//  ALUSRCB    out  2  ALU B select: 0 = regB, 1 = const 4, 2 = signext imm, 3 = signext imm<<2
//  ALUOP      out  2  00 = add, 01 = sub, 10 = decode funct
//  PCSRC      out  2  PC mux: 0 = ALUResult, 1 = ALUOut, 2 = jump target, 3 = exception vector
//  PCEN       out  1  PC load enable
//  EXC        out  1  one-cycle pulse on entering EXCEPT
//  STATE      out  4  current state code (debug)
// BEHAVIOUR
//  Reset: async on RST_N low -> state FETCH; wait counter 0.
//   While RST_N is low, MEM_REQ/MEMWRITE/IRWRITE/REGWRITE/PCEN/EXC = 0.
//   All other outputs are 0 during reset.
//  Outputs: Moore-decoded from state, except IRWRITE, PCEN and MEMWRITE completion, which are gated by inputs.
//   Any output not listed for a state is 0.
//  States and codes:
//   FETCH=0    MEM_REQ, IORD=0, ALUSRCA=0, ALUSRCB=1, ALUOP=00, PCSRC=0.
//              IRWRITE = PCEN = MEM_READY. Stay while !MEM_READY, else -> DECODE.
//   DECODE=1   ALUSRCA=0, ALUSRCB=3, ALUOP=00.
//              Next by OP: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX,
//              000010 -> JUMP, else -> EXCEPT (ILLEGAL_TRAP=1) or FETCH.
//   MEMADR=2   ALUSRCA=1, ALUSRCB=2, ALUOP=00. -> MEMRD if OP=100011, else -> MEMWR.
//   MEMRD=3    MEM_REQ, IORD=1. Hold until MEM_READY, then -> MEMWB.
//   MEMWB=4    REGDST=0, MEMTOREG=1, REGWRITE. -> FETCH.
//   MEMWR=5    MEM_REQ, IORD=1, MEMWRITE held high. Hold until MEM_READY, then -> FETCH.
//   EXEC=6     ALUSRCA=1, ALUSRCB=0, ALUOP=10. -> ALUWB.
//   ALUWB=7    REGDST=1, MEMTOREG=0, REGWRITE. -> FETCH.
//   BRANCH=8   ALUSRCA=1, ALUSRCB=0, ALUOP=01, PCSRC=1, PCEN=ZERO. -> FETCH.
//   ADDIEX=9   ALUSRCA=1, ALUSRCB=2, ALUOP=00. -> ADDIWB.
//   ADDIWB=10  REGDST=0, MEMTOREG=0, REGWRITE. -> FETCH.
//   JUMP=11    PCSRC=2, PCEN. -> FETCH.
//   EXCEPT=12  PCSRC=3, PCEN, EXC. -> FETCH.
//   Codes 13-15 are unreachable; if entered -> FETCH with all enables 0.
//  Wait counter: counts cycles in FETCH/MEMRD/MEMWR with MEM_REQ=1 and MEM_READY=0.
//   Cleared on state change.
//   If WAIT_MAX!=0 and counter reaches WAIT_MAX with MEM_READY still 0 -> EXCEPT next cycle.
//   On that cycle no IRWRITE, REGWRITE or PCEN is issued.
//   MEM_READY on the same cycle the limit is reached wins: normal transition.
//  Latency (zero-wait memory): R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
//  Reset mid-instruction: any in-flight access is abandoned; MEM_REQ drops asynchronously.
//  MEM_READY outside a request state is ignored.
// STRUCTURE
//  Package mc_ctrl_pkg: state_t enum (4-bit codes above), opcode localparams, ALUSRCB_*/PCSRC_*/ALUOP_* constants.
//  Sub-module mc_ctrl_outdec: pure combinational state -> control-word decoder.
//  State register, next-state logic and wait counter live in mc_control_fsm.
// TESTING
//  1. Reset, OP=000000, MEM_READY=1 -> STATE 0,1,6,7,0.
//     ALUSRCB 1,3,0,x; REGWRITE=1 only in state 7; REGDST=1.
//  2. lw (OP=100011), MEM_READY low 3 cycles in MEMRD -> MEM_REQ=1, IORD=1 held 4 cycles.
//     Then MEMWB with MEMTOREG=1, REGWRITE=1.
//  3. beq (OP=000100) with ZERO=1 -> PCSRC=1, PCEN=1 in state 8. Repeat with ZERO=0 -> PCEN=0.
//  4. OP=111111, ILLEGAL_TRAP=1 -> DECODE->EXCEPT, PCSRC=3, PCEN=1, EXC one-cycle pulse, then FETCH.
//  5. WAIT_MAX=4, MEM_READY stuck 0 in FETCH -> EXCEPT on 5th cycle, IRWRITE never 1.
//  6. Drive RST_N low mid-MEMWR -> MEMWRITE=0 and STATE=0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state codes, opcodes and mux-select constants for the multicycle control FSM
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_EXCEPT = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUSRCB_REGB  = 2'd0;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'd1;
   localparam logic [1:0] ALUSRCB_IMM   = 2'd2;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_EXC    = 2'd3;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // States that hold a memory request open and can therefore accumulate wait cycles
   function automatic logic is_mem_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state to control-word decoder
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state_code,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       exc
);

   always_comb begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = ALUSRCB_REGB;
      aluop    = ALUOP_ADD;
      pcsrc    = PCSRC_ALU;
      pcen     = 1'b0;
      exc      = 1'b0;
      case (state_t'(state_code))
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = ALUSRCB_FOUR;
            irwrite = mem_ready;
            pcen    = mem_ready;
         end
         S_DECODE: alusrcb = ALUSRCB_IMMSH;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            pcen    = zero;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = PCSRC_JUMP;
            pcen  = 1'b1;
         end
         S_EXCEPT: begin
            pcsrc = PCSRC_EXC;
            pcen  = 1'b1;
            exc   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control FSM with memory wait-limit watchdog
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int WAIT_MAX     = 0,
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       exc,
   output logic [3:0] state
);

   localparam logic [15:0] WAIT_LIM = 16'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

   state_t      state_q, state_d;
   logic [15:0] wait_cnt;
   logic        waiting, timeout;

   logic       d_mem_req, d_iord, d_memwrite, d_irwrite, d_regdst, d_memtoreg;
   logic       d_regwrite, d_alusrca, d_pcen, d_exc;
   logic [1:0] d_alusrcb, d_aluop, d_pcsrc;

   assign waiting = is_mem_state(state_q) && !mem_ready;
   // Fires on the WAIT_MAX-th stalled cycle so EXCEPT is entered on the following one
   assign timeout = (WAIT_MAX != 0) && waiting && (wait_cnt == WAIT_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (waiting && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = ILLEGAL_TRAP ? S_EXCEPT : S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
      if (timeout)
         state_d = S_EXCEPT;
   end

   mc_ctrl_outdec u_outdec (
      .state_code (state_q),
      .mem_ready  (mem_ready),
      .zero       (zero),
      .mem_req    (d_mem_req),
      .iord       (d_iord),
      .memwrite   (d_memwrite),
      .irwrite    (d_irwrite),
      .regdst     (d_regdst),
      .memtoreg   (d_memtoreg),
      .regwrite   (d_regwrite),
      .alusrca    (d_alusrca),
      .alusrcb    (d_alusrcb),
      .aluop      (d_aluop),
      .pcsrc      (d_pcsrc),
      .pcen       (d_pcen),
      .exc        (d_exc)
   );

   // Gating by rst_n makes every output drop the instant reset asserts, not at the next edge
   always_comb begin
      mem_req  = rst_n & d_mem_req;
      iord     = rst_n & d_iord;
      memwrite = rst_n & d_memwrite;
      irwrite  = rst_n & d_irwrite;
      regdst   = rst_n & d_regdst;
      memtoreg = rst_n & d_memtoreg;
      regwrite = rst_n & d_regwrite;
      alusrca  = rst_n & d_alusrca;
      alusrcb  = rst_n ? d_alusrcb : 2'd0;
      aluop    = rst_n ? d_aluop : 2'd0;
      pcsrc    = rst_n ? d_pcsrc : 2'd0;
      pcen     = rst_n & d_pcen;
      exc      = rst_n & d_exc;
      state    = rst_n ? state_q : 4'd0;
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed-vector self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;

   logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, exc;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;

   logic       w_mem_req, w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
   logic       w_alusrca, w_pcen, w_exc;
   logic [1:0] w_alusrcb, w_aluop, w_pcsrc;
   logic [3:0] w_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mc_control_fsm u_dut (
      .clk (clk), .rst_n (rst_n), .op (op), .zero (zero), .mem_ready (mem_ready),
      .mem_req (mem_req), .iord (iord), .memwrite (memwrite), .irwrite (irwrite),
      .regdst (regdst), .memtoreg (memtoreg), .regwrite (regwrite), .alusrca (alusrca),
      .alusrcb (alusrcb), .aluop (aluop), .pcsrc (pcsrc), .pcen (pcen), .exc (exc),
      .state (state)
   );

   mc_control_fsm #(.WAIT_MAX (4), .ILLEGAL_TRAP (1'b1)) u_dut_wd (
      .clk (clk), .rst_n (rst_n), .op (op), .zero (zero), .mem_ready (mem_ready),
      .mem_req (w_mem_req), .iord (w_iord), .memwrite (w_memwrite), .irwrite (w_irwrite),
      .regdst (w_regdst), .memtoreg (w_memtoreg), .regwrite (w_regwrite), .alusrca (w_alusrca),
      .alusrcb (w_alusrcb), .aluop (w_aluop), .pcsrc (w_pcsrc), .pcen (w_pcen), .exc (w_exc),
      .state (w_state)
   );

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
      #12;
      check_eq("rst_state", 8'(state), 8'd0);
      check_eq("rst_mem_req", 8'(mem_req), 8'd0);
      check_eq("rst_alusrcb", 8'(alusrcb), 8'd0);
      check_eq("rst_irwrite", 8'(irwrite), 8'd0);

      // R-type
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1; op = 6'b000000;
      #1;
      check_eq("r_fetch_state", 8'(state), 8'd0);
      check_eq("r_fetch_srcb", 8'(alusrcb), 8'd1);
      check_eq("r_fetch_irw", 8'(irwrite), 8'd1);
      check_eq("r_fetch_pcen", 8'(pcen), 8'd1);
      check_eq("r_fetch_req", 8'(mem_req), 8'd1);
      step();
      check_eq("r_dec_state", 8'(state), 8'd1);
      check_eq("r_dec_srcb", 8'(alusrcb), 8'd3);
      check_eq("r_dec_regw", 8'(regwrite), 8'd0);
      step();
      check_eq("r_exec_state", 8'(state), 8'd6);
      check_eq("r_exec_srcb", 8'(alusrcb), 8'd0);
      check_eq("r_exec_aluop", 8'(aluop), 8'd2);
      check_eq("r_exec_regw", 8'(regwrite), 8'd0);
      step();
      check_eq("r_wb_state", 8'(state), 8'd7);
      check_eq("r_wb_regw", 8'(regwrite), 8'd1);
      check_eq("r_wb_regdst", 8'(regdst), 8'd1);
      step();
      check_eq("r_done_state", 8'(state), 8'd0);

      // lw with three wait cycles in MEMRD
      op = 6'b100011;
      step();
      check_eq("lw_dec_state", 8'(state), 8'd1);
      step();
      check_eq("lw_adr_state", 8'(state), 8'd2);
      check_eq("lw_adr_srcb", 8'(alusrcb), 8'd2);
      check_eq("lw_adr_srca", 8'(alusrca), 8'd1);
      mem_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check_eq("lw_rd_state", 8'(state), 8'd3);
         check_eq("lw_rd_req", 8'(mem_req), 8'd1);
         check_eq("lw_rd_iord", 8'(iord), 8'd1);
         step();
      end
      mem_ready = 1'b1;
      #1;
      check_eq("lw_rd4_state", 8'(state), 8'd3);
      check_eq("lw_rd4_req", 8'(mem_req), 8'd1);
      check_eq("lw_rd4_iord", 8'(iord), 8'd1);
      step();
      check_eq("lw_wb_state", 8'(state), 8'd4);
      check_eq("lw_wb_m2r", 8'(memtoreg), 8'd1);
      check_eq("lw_wb_regw", 8'(regwrite), 8'd1);
      check_eq("lw_wb_regdst", 8'(regdst), 8'd0);
      check_eq("lw_wd_state", 8'(w_state), 8'd4);
      step();
      check_eq("lw_done_state", 8'(state), 8'd0);

      // beq taken then not taken
      op = 6'b000100; zero = 1'b1;
      step();
      step();
      check_eq("beq1_state", 8'(state), 8'd8);
      check_eq("beq1_pcsrc", 8'(pcsrc), 8'd1);
      check_eq("beq1_pcen", 8'(pcen), 8'd1);
      check_eq("beq1_aluop", 8'(aluop), 8'd1);
      step();
      check_eq("beq1_done", 8'(state), 8'd0);
      zero = 1'b0;
      step();
      step();
      check_eq("beq0_state", 8'(state), 8'd8);
      check_eq("beq0_pcen", 8'(pcen), 8'd0);
      step();

      // illegal opcode trap
      op = 6'b111111;
      step();
      check_eq("ill_dec_state", 8'(state), 8'd1);
      step();
      check_eq("ill_exc_state", 8'(state), 8'd12);
      check_eq("ill_pcsrc", 8'(pcsrc), 8'd3);
      check_eq("ill_pcen", 8'(pcen), 8'd1);
      check_eq("ill_exc", 8'(exc), 8'd1);
      step();
      check_eq("ill_after_state", 8'(state), 8'd0);
      check_eq("ill_after_exc", 8'(exc), 8'd0);

      // watchdog: memory never ready in FETCH
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_eq("wd_wait_state", 8'(w_state), 8'd0);
         check_eq("wd_wait_irw", 8'(w_irwrite), 8'd0);
         check_eq("wd_wait_exc", 8'(w_exc), 8'd0);
         step();
      end
      check_eq("wd_exc_state", 8'(w_state), 8'd12);
      check_eq("wd_exc_pulse", 8'(w_exc), 8'd1);
      check_eq("wd_exc_irw", 8'(w_irwrite), 8'd0);
      check_eq("unbounded_state", 8'(state), 8'd0);

      // reset asserted mid-MEMWR
      op = 6'b101011; mem_ready = 1'b1;
      step();
      check_eq("sw_dec_state", 8'(state), 8'd1);
      step();
      mem_ready = 1'b0;
      step();
      check_eq("sw_wr_state", 8'(state), 8'd5);
      check_eq("sw_wr_memw", 8'(memwrite), 8'd1);
      check_eq("sw_wr_req", 8'(mem_req), 8'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_memw", 8'(memwrite), 8'd0);
      check_eq("arst_req", 8'(mem_req), 8'd0);
      check_eq("arst_state", 8'(state), 8'd0);
      check_eq("arst_iord", 8'(iord), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
